// File: rtl/fare_pkg.sv
// Shared definitions for the fare settlement block: FSM states, coin codes and
// the coin-code to face-value mapping.
package fare_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_CHANGE  = 2'd2;
  localparam state_t ST_CLEAR   = 2'd3;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_5  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;
  localparam logic [1:0] COIN_50 = 2'b11;

  localparam int SEAT_VIP = 4;

  function automatic logic [5:0] coin_amount(input logic [1:0] code);
    logic [5:0] amt;
    case (code)
      COIN_1:  amt = 6'd1;
      COIN_5:  amt = 6'd5;
      COIN_10: amt = 6'd10;
      default: amt = 6'd50;
    endcase
    return amt;
  endfunction

endpackage

// File: rtl/fare_change_picker.sv
// Chooses the largest coin not exceeding the outstanding change and reports
// both its code and its face value.
module fare_change_picker
  import fare_pkg::*;
#(
  parameter int W = 15
) (
  input  logic [W-1:0] remainder,
  output logic [1:0]   change_value,
  output logic [5:0]   change_amount
);

  always_comb begin
    change_value = COIN_1;
    if (remainder >= W'(50))
      change_value = COIN_50;
    else if (remainder >= W'(10))
      change_value = COIN_10;
    else if (remainder >= W'(5))
      change_value = COIN_5;
    change_amount = coin_amount(change_value);
  end

endmodule

// File: rtl/fare_settlement.sv
// Settles one passenger fare at a time: latch fare, collect coins, dispense
// change, clear the meter seat and add the fare to the session total.
// Optional idle-coin refund timeout is built when FARE_TIMEOUT_EN is defined.
module fare_settlement
  import fare_pkg::*;
#(
  parameter int COST_W         = 14,
  parameter int TOTAL_W        = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [COST_W-1:0]  seat_cost_0,
  input  logic [COST_W-1:0]  seat_cost_1,
  input  logic [COST_W-1:0]  seat_cost_2,
  input  logic [COST_W-1:0]  seat_cost_3,
  input  logic [COST_W-1:0]  vip_cost,
  input  logic [4:0]         exit_req,
  output logic               busy,
  output logic [COST_W-1:0]  amount_due,
  input  logic               coin_valid,
  input  logic [1:0]         coin_value,
  output logic               coin_ready,
  output logic               change_valid,
  output logic [1:0]         change_value,
  input  logic               change_ready,
  output logic [4:0]         seat_clear,
  output logic [TOTAL_W-1:0] paid_total,
  output logic               timeout_flag
);

  state_t            state;
  logic [2:0]        sel;
  logic [COST_W-1:0] fare;
  logic [COST_W:0]   credit;
  logic [COST_W:0]   remainder;
  logic              refund;

  logic [2:0]        pick_idx;
  logic [COST_W-1:0] pick_cost;
  logic              coin_accept;
  logic [COST_W:0]   fare_ext;
  logic [COST_W:0]   credit_sum;
  logic [COST_W:0]   remainder_less;
  logic [1:0]        pick_value;
  logic [5:0]        pick_amount;
  logic [TOTAL_W:0]  paid_sum;
  logic [TOTAL_W-1:0] paid_next;
  logic              timeout_hit;

  // Lowest-numbered requesting seat wins; VIP (bit 4) has the lowest priority.
  always_comb begin
    pick_idx = 3'd0;
    for (int i = SEAT_VIP; i >= 0; i--) begin
      if (exit_req[i])
        pick_idx = 3'(i);
    end
  end

  always_comb begin
    case (pick_idx)
      3'd0:    pick_cost = seat_cost_0;
      3'd1:    pick_cost = seat_cost_1;
      3'd2:    pick_cost = seat_cost_2;
      3'd3:    pick_cost = seat_cost_3;
      default: pick_cost = vip_cost;
    endcase
  end

  fare_change_picker #(.W(COST_W + 1)) u_picker (
    .remainder     (remainder),
    .change_value  (pick_value),
    .change_amount (pick_amount)
  );

  assign coin_accept    = coin_valid && (state == ST_COLLECT);
  assign fare_ext       = {1'b0, fare};
  assign credit_sum     = credit + (COST_W + 1)'(coin_amount(coin_value));
  assign remainder_less = remainder - (COST_W + 1)'(pick_amount);

  // Session total saturates instead of wrapping.
  assign paid_sum  = {1'b0, paid_total} + (TOTAL_W + 1)'(fare);
  assign paid_next = paid_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : paid_sum[TOTAL_W-1:0];

  assign busy         = (state != ST_IDLE);
  assign coin_ready   = (state == ST_COLLECT);
  assign amount_due   = (state == ST_COLLECT) ? (fare - credit[COST_W-1:0]) : '0;
  assign change_valid = (state == ST_CHANGE) && (remainder != '0);
  assign change_value = change_valid ? pick_value : 2'b00;
  assign seat_clear   = (state == ST_CLEAR) ? (5'd1 << sel) : 5'd0;

`ifdef FARE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] idle_cnt;

  // Counts cycles without an accepted coin while collecting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      idle_cnt <= '0;
    else if ((state != ST_COLLECT) || coin_accept)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout_hit  = (state == ST_COLLECT) && !coin_accept &&
                        (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_hit;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sel        <= 3'd0;
      fare       <= '0;
      credit     <= '0;
      remainder  <= '0;
      refund     <= 1'b0;
      paid_total <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|exit_req) begin
            sel       <= pick_idx;
            fare      <= pick_cost;
            credit    <= '0;
            remainder <= '0;
            refund    <= 1'b0;
            state     <= (pick_cost == '0) ? ST_CLEAR : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (coin_accept) begin
            credit <= credit_sum;
            if (credit_sum >= fare_ext) begin
              remainder <= credit_sum - fare_ext;
              state     <= (credit_sum == fare_ext) ? ST_CLEAR : ST_CHANGE;
            end
          end else if (timeout_hit) begin
            // Abort: whatever was inserted is handed back as change.
            remainder <= credit;
            refund    <= 1'b1;
            state     <= (credit == '0) ? ST_IDLE : ST_CHANGE;
          end
        end
        ST_CHANGE: begin
          if (change_valid && change_ready) begin
            remainder <= remainder_less;
            if (remainder_less == '0)
              state <= refund ? ST_IDLE : ST_CLEAR;
          end
        end
        default: begin
          paid_total <= paid_next;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
